pong_ball_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_ball_ctrl_if.sv | 35 +++
 rtl/pong_tick_gen.sv | 29 ++
 rtl/pong_ball_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared screen geometry, ball state encoding and direction type for the
// Pong ball engine.
package pong_pkg;

   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int BALL_SZ = 8;
   localparam int PAD_W   = 8;
   localparam int PAD_H   = 100;
   localparam int LPAD_X  = 32;
   localparam int RPAD_X  = 600;

   localparam logic [9:0] BALL_X0 = 10'd316;
   localparam logic [9:0] BALL_Y0 = 10'd236;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      SCORE = 2'd2,
      OVER  = 2'd3
   } ball_state_t;

   // Negative means left (x) or up (y); positive means right or down.
   typedef enum logic {
      DIR_NEG = 1'b0,
      DIR_POS = 1'b1
   } dir_t;

endpackage

// File: rtl/pong_ball_ctrl_if.sv
// Signal bundle between the ball engine and its neighbours.
// There is no valid/ready handshake here: paddle positions are level
// signals that the engine samples only on its movement tick, and every
// output is a registered level except point_l/point_r, which are one-clk
// pulses. dbg_state and dbg_tick expose the engine FSM and its tick.
interface pong_ball_ctrl_if;
   import pong_pkg::*;

   logic [9:0]  l_y;
   logic [9:0]  r_y;
   logic [9:0]  ball_x;
   logic [9:0]  ball_y;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic        point_l;
   logic        point_r;
   logic        game_over;
   ball_state_t dbg_state;
   logic        dbg_tick;

   // Ball engine side.
   modport master (
      input  l_y, r_y,
      output ball_x, ball_y, score_l, score_r, point_l, point_r, game_over,
      output dbg_state, dbg_tick
   );

   // Paddle controllers / renderer / score display side.
   modport slave (
      output l_y, r_y,
      input  ball_x, ball_y, score_l, score_r, point_l, point_r, game_over,
      input  dbg_state, dbg_tick
   );

endinterface

// File: rtl/pong_tick_gen.sv
// Free-running prescaler: tick is high for one clk every TICK_DIV clks,
// on the cycle the counter sits at TICK_DIV-1.
module pong_tick_gen #(
   parameter int TICK_DIV = 262144
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick decode and wrap-around count.
   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball motion and scoring engine: serves from centre, moves the ball one
// STEP per tick, reflects off walls and paddles, and scores misses.
module pong_ball_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 262144,
   parameter int STEP        = 1,
   parameter int SERVE_TICKS = 64,
   parameter int MAX_SCORE   = 9
) (
   input logic              clk,
   input logic              rst_n,
   pong_ball_ctrl_if.master bus
);

   localparam int             SCW        = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_TICKS - 1);
   localparam logic [3:0]     MAX4       = 4'(MAX_SCORE);

   // Geometry constants widened to 11 bits so sums never wrap.
   localparam logic [10:0] S11   = 11'(STEP);
   localparam logic [10:0] BSZ   = 11'(BALL_SZ);
   localparam logic [10:0] HR    = 11'(H_RES);
   localparam logic [10:0] VR    = 11'(V_RES);
   localparam logic [10:0] RPX   = 11'(RPAD_X);
   localparam logic [10:0] LFACE = 11'(LPAD_X + PAD_W);
   localparam logic [10:0] PH    = 11'(PAD_H);

   ball_state_t    state_q,     state_d;
   logic [9:0]     ball_x_q,    ball_x_d;
   logic [9:0]     ball_y_q,    ball_y_d;
   dir_t           dir_x_q,     dir_x_d;
   dir_t           dir_y_q,     dir_y_d;
   logic [3:0]     score_l_q,   score_l_d;
   logic [3:0]     score_r_q,   score_r_d;
   logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
   logic           point_l_q,   point_l_d;
   logic           point_r_q,   point_r_d;
   logic           game_over_q, game_over_d;

   logic        tick;
   logic [10:0] x11, y11, nx, ny, ly11, ry11;
   logic        hit_bot, hit_top, hit_r, hit_l, miss_r, miss_l;

   pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Candidate position and collision / miss detection for the current tick.
   always_comb begin
      x11     = {1'b0, ball_x_q};
      y11     = {1'b0, ball_y_q};
      ly11    = {1'b0, bus.l_y};
      ry11    = {1'b0, bus.r_y};
      nx      = (dir_x_q == DIR_POS) ? x11 + S11 : x11 - S11;
      ny      = (dir_y_q == DIR_POS) ? y11 + S11 : y11 - S11;
      hit_bot = (dir_y_q == DIR_POS) && (y11 + BSZ + S11 >= VR);
      hit_top = (dir_y_q == DIR_NEG) && (y11 < S11);
      hit_r   = (dir_x_q == DIR_POS) && (x11 + BSZ <= RPX) && (x11 + BSZ + S11 >= RPX)
                && (y11 + BSZ > ry11) && (y11 < ry11 + PH);
      hit_l   = (dir_x_q == DIR_NEG) && (x11 >= LFACE) && (x11 <= LFACE + S11)
                && (y11 + BSZ > ly11) && (y11 < ly11 + PH);
      miss_r  = (dir_x_q == DIR_POS) && (x11 + BSZ + S11 >= HR);
      miss_l  = (dir_x_q == DIR_NEG) && (x11 < S11);
   end

   // Next-state and datapath updates for the serve/play/score/over FSM.
   always_comb begin
      state_d     = state_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      serve_cnt_d = serve_cnt_q;
      point_l_d   = 1'b0;
      point_r_d   = 1'b0;
      case (state_q)
         SERVE: begin
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
            if (tick) begin
               if (serve_cnt_q == SERVE_LAST) begin
                  serve_cnt_d = '0;
                  state_d     = PLAY;
               end else begin
                  serve_cnt_d = serve_cnt_q + 1'b1;
               end
            end
         end
         PLAY: begin
            if (tick) begin
               if (hit_bot) begin
                  ball_y_d = 10'(V_RES - BALL_SZ);
                  dir_y_d  = DIR_NEG;
               end else if (hit_top) begin
                  ball_y_d = '0;
                  dir_y_d  = DIR_POS;
               end else begin
                  ball_y_d = ny[9:0];
               end
               // On a miss x is left where it was; SCORE recentres it anyway.
               if (miss_r) begin
                  score_l_d = score_l_q + 4'd1;
                  point_l_d = 1'b1;
                  state_d   = SCORE;
               end else if (miss_l) begin
                  score_r_d = score_r_q + 4'd1;
                  point_r_d = 1'b1;
                  state_d   = SCORE;
               end else if (hit_r) begin
                  ball_x_d = 10'(RPAD_X - BALL_SZ);
                  dir_x_d  = DIR_NEG;
               end else if (hit_l) begin
                  ball_x_d = 10'(LPAD_X + PAD_W);
                  dir_x_d  = DIR_POS;
               end else begin
                  ball_x_d = nx[9:0];
               end
            end
         end
         SCORE: begin
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            dir_y_d     = DIR_POS;
            serve_cnt_d = '0;
            // Serve toward the player who just conceded.
            dir_x_d     = point_l_q ? DIR_POS : DIR_NEG;
            state_d     = ((score_l_q == MAX4) || (score_r_q == MAX4)) ? OVER : SERVE;
         end
         OVER: begin
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
         end
         default: state_d = SERVE;
      endcase
      game_over_d = (state_d == OVER);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= SERVE;
         ball_x_q    <= BALL_X0;
         ball_y_q    <= BALL_Y0;
         dir_x_q     <= DIR_POS;
         dir_y_q     <= DIR_POS;
         score_l_q   <= '0;
         score_r_q   <= '0;
         serve_cnt_q <= '0;
         point_l_q   <= 1'b0;
         point_r_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         serve_cnt_q <= serve_cnt_d;
         point_l_q   <= point_l_d;
         point_r_q   <= point_r_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.ball_x    = ball_x_q;
   assign bus.ball_y    = ball_y_q;
   assign bus.score_l   = score_l_q;
   assign bus.score_r   = score_r_q;
   assign bus.point_l   = point_l_q;
   assign bus.point_r   = point_r_q;
   assign bus.game_over = game_over_q;
   assign bus.dbg_state = state_q;
   assign bus.dbg_tick  = tick;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl with TICK_DIV=4, STEP=1,
// SERVE_TICKS=4, MAX_SCORE=2. All expected values are hand-derived
// trajectory points counted in clks from a reset release.
module tb_pong_ball_ctrl;
   import pong_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_l  = 0;
   int pulse_r  = 0;

   pong_ball_ctrl_if bus ();

   pong_ball_ctrl #(
      .TICK_DIV    (4),
      .STEP        (1),
      .SERVE_TICKS (4),
      .MAX_SCORE   (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock.
   always #5 clk = ~clk;

   // Count point pulses on the falling edge.
   always @(negedge clk) begin
      if (bus.point_l) pulse_l++;
      if (bus.point_r) pulse_r++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_ball(input string tag, input int x, input int y);
      chk({tag, "_x"}, 32'(bus.ball_x), 32'(x));
      chk({tag, "_y"}, 32'(bus.ball_y), 32'(y));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_ball(tag, 316, 236);
      chk({tag, "_score_l"}, 32'(bus.score_l), 32'd0);
      chk({tag, "_score_r"}, 32'(bus.score_r), 32'd0);
      chk({tag, "_point_l"}, 32'(bus.point_l), 32'd0);
      chk({tag, "_point_r"}, 32'(bus.point_r), 32'd0);
      chk({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
      chk({tag, "_state"}, 32'(bus.dbg_state), 32'(SERVE));
      chk({tag, "_tick"}, 32'(bus.dbg_tick), 32'd0);
   endtask

   initial begin
      // Reset / serve
      bus.l_y = 10'd100;
      bus.r_y = 10'd380;
      rst_n   = 1'b0;
      step(3);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      step(3);
      chk("first_tick", 32'(bus.dbg_tick), 32'd1);
      step(16);                       // edge 19: serve over, not yet moved
      chk_ball("serve_hold", 316, 236);
      chk("serve_to_play", 32'(bus.dbg_state), 32'(PLAY));
      step(1);                        // edge 20: first play tick
      chk_ball("launch", 317, 237);

      // Bottom wall after 236 play ticks
      step(4 * 235);
      chk_ball("bottom_wall", 552, 472);
      step(4);
      chk_ball("after_bottom", 553, 471);

      // Right paddle hit (r_y=380)
      step(4 * 39);
      chk_ball("rpad_hit", 592, 432);
      step(4);
      chk_ball("after_rpad", 591, 431);
      chk("rpad_no_pulse_l", 32'(pulse_l), 32'd0);
      chk("rpad_no_pulse_r", 32'(pulse_r), 32'd0);

      // Right miss with r_y=100
      bus.r_y = 10'd100;
      rst_n   = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(16 + 4 * 315);             // edge 1276
      chk("miss_pre_x", 32'(bus.ball_x), 32'd631);
      chk("miss_pre_point", 32'(bus.point_l), 32'd0);
      step(4);                        // edge 1280
      chk("miss_point_l", 32'(bus.point_l), 32'd1);
      chk("miss_point_r", 32'(bus.point_r), 32'd0);
      chk("miss_score_l", 32'(bus.score_l), 32'd1);
      chk("miss_state", 32'(bus.dbg_state), 32'(SCORE));
      step(1);                        // edge 1281
      chk("pulse_end", 32'(bus.point_l), 32'd0);
      chk_ball("recentre", 316, 236);
      chk("rec_state", 32'(bus.dbg_state), 32'(SERVE));
      chk("rec_not_over", 32'(bus.game_over), 32'd0);
      chk("one_pulse", 32'(pulse_l), 32'd1);
      step(18);                       // edge 1299
      chk_ball("reserve_hold", 316, 236);
      step(1);                        // edge 1300
      chk_ball("relaunch_right", 317, 237);

      // Second miss reaches MAX_SCORE=2
      step(4 * 315);                  // edge 2560
      chk("miss2_point_l", 32'(bus.point_l), 32'd1);
      chk("miss2_score_l", 32'(bus.score_l), 32'd2);
      step(1);
      chk("over_flag", 32'(bus.game_over), 32'd1);
      chk("over_state", 32'(bus.dbg_state), 32'(OVER));
      chk_ball("over_ball", 316, 236);
      step(4 * 100);
      chk_ball("over_frozen", 316, 236);
      chk("over_score_l", 32'(bus.score_l), 32'd2);
      chk("over_score_r", 32'(bus.score_r), 32'd0);
      chk("over_flag_hold", 32'(bus.game_over), 32'd1);
      chk("over_pulse_l", 32'(pulse_l), 32'd2);
      chk("over_pulse_r", 32'(pulse_r), 32'd0);

      // One-clk reset out of OVER, then reset mid-play
      rst_n = 1'b0;
      step(1);
      chk_reset_vals("rst_over");
      rst_n = 1'b1;
      step(16 + 4 * 84);              // edge 352
      chk_ball("midplay", 400, 320);
      chk("midplay_state", 32'(bus.dbg_state), 32'(PLAY));
      step(1);
      rst_n = 1'b0;
      step(1);
      chk_reset_vals("rst_mid");
      rst_n = 1'b1;
      step(2);
      chk("tick_restart_lo", 32'(bus.dbg_tick), 32'd0);
      step(1);
      chk("tick_restart_hi", 32'(bus.dbg_tick), 32'd1);
      step(16);                       // edge 19
      chk_ball("mid_serve_hold", 316, 236);
      step(1);                        // edge 20
      chk_ball("mid_relaunch", 317, 237);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
